// File: rtl/imem_uart_loader.sv
// Instruction memory loader: receives a framed program over the UART byte stream,
// packs little-endian words into instruction memory and holds the core until a frame
// loads with a good checksum.
module imem_uart_loader #(
    parameter int unsigned IMEM_DEPTH     = 512,
    parameter int unsigned W_IADDR        = $clog2(IMEM_DEPTH),
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               imem_wen,
    output logic [W_IADDR-1:0] imem_waddr,
    output logic [31:0]        imem_wdata,
    output logic               ins_mem_en,
    output logic               cpu_reset,
    output logic               loaded,
    output logic               done,
    output logic               error
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StCntLo,
        StCntHi,
        StData,
        StCheck,
        StErr
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        n_q, n_d;
    logic [15:0]        word_cnt_q, word_cnt_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [7:0]         csum_q, csum_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic               wen_q, wen_d;
    logic [W_IADDR-1:0] waddr_q, waddr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               ins_mem_en_q, ins_mem_en_d;
    logic               cpu_reset_q, cpu_reset_d;
    logic               loaded_q, loaded_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic [15:0]        n_full;
    logic               in_frame;

    assign n_full   = {rx_data, n_q[7:0]};
    assign in_frame = (state_q == StCntLo) || (state_q == StCntHi) ||
                      (state_q == StData)  || (state_q == StCheck);

    // Next-state: frame parsing, word packing, checksum and inter-byte timeout.
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        word_cnt_d   = word_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        csum_d       = csum_q;
        tmo_d        = tmo_q;
        wen_d        = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        ins_mem_en_d = ins_mem_en_q;
        cpu_reset_d  = cpu_reset_q;
        loaded_d     = loaded_q;
        done_d       = 1'b0;
        error_d      = error_q;

        // Address advances the cycle after a write, except after the final word so it
        // never steps past the last valid location.
        if (wen_q && (word_cnt_q != n_q)) begin
            waddr_d = waddr_q + W_IADDR'(1);
        end

        unique case (state_q)
            StIdle, StErr: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_d      = StCntLo;
                    cpu_reset_d  = 1'b1;
                    ins_mem_en_d = 1'b1;
                    loaded_d     = 1'b0;
                    error_d      = 1'b0;
                    waddr_d      = '0;
                    byte_cnt_d   = '0;
                    word_cnt_d   = '0;
                    csum_d       = '0;
                    tmo_d        = '0;
                end
            end
            StCntLo: begin
                if (rx_valid) begin
                    n_d     = {8'h00, rx_data};
                    state_d = StCntHi;
                end
            end
            StCntHi: begin
                if (rx_valid) begin
                    n_d = n_full;
                    if ((n_full == 16'd0) || (17'(n_full) > 17'(IMEM_DEPTH))) begin
                        state_d = StErr;
                        error_d = 1'b1;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (rx_valid) begin
                    wdata_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
                    csum_d     = csum_q ^ rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        wen_d      = 1'b1;
                        word_cnt_d = word_cnt_q + 16'd1;
                        if ((word_cnt_q + 16'd1) == n_q) begin
                            state_d = StCheck;
                        end
                    end
                end
            end
            StCheck: begin
                if (rx_valid) begin
                    if (rx_data == csum_q) begin
                        state_d      = StIdle;
                        done_d       = 1'b1;
                        loaded_d     = 1'b1;
                        cpu_reset_d  = 1'b0;
                        ins_mem_en_d = 1'b0;
                    end else begin
                        state_d = StErr;
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Inter-byte timeout only runs while a frame is open.
        if (in_frame) begin
            if (rx_valid) begin
                tmo_d = '0;
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d      = StErr;
                error_d      = 1'b1;
                cpu_reset_d  = 1'b1;
                ins_mem_en_d = 1'b1;
                tmo_d        = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            n_q          <= '0;
            word_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            csum_q       <= '0;
            tmo_q        <= '0;
            wen_q        <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            ins_mem_en_q <= 1'b1;
            cpu_reset_q  <= 1'b1;
            loaded_q     <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            word_cnt_q   <= word_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            csum_q       <= csum_d;
            tmo_q        <= tmo_d;
            wen_q        <= wen_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            ins_mem_en_q <= ins_mem_en_d;
            cpu_reset_q  <= cpu_reset_d;
            loaded_q     <= loaded_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign imem_wen   = wen_q;
    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;
    assign ins_mem_en = ins_mem_en_q;
    assign cpu_reset  = cpu_reset_q;
    assign loaded     = loaded_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: frames are driven byte by byte, expected memory writes
// are queued as they are sent and matched against the write port by a monitor.
module tb_imem_uart_loader;

    localparam int unsigned AW = 9;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          imem_wen;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          ins_mem_en, cpu_reset, loaded, done, error;

    int checks = 0;
    int errors = 0;
    int wen_cnt = 0;
    int done_cnt = 0;

    logic [AW+31:0] exp_q[$];
    logic [31:0]    frame_w[8];

    imem_uart_loader #(
        .IMEM_DEPTH(512),
        .W_IADDR(AW),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .clock(clock),
        .reset(reset),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .imem_wen(imem_wen),
        .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata),
        .ins_mem_en(ins_mem_en),
        .cpu_reset(cpu_reset),
        .loaded(loaded),
        .done(done),
        .error(error)
    );

    always #5 clock = ~clock;

    // Scoreboard: every write strobe must match the oldest queued expectation.
    always @(negedge clock) begin
        if (done) done_cnt++;
        if (imem_wen) begin
            wen_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_wen addr=%0d data=%h", imem_waddr, imem_wdata);
            end else begin
                logic [AW+31:0] e;
                e = exp_q.pop_front();
                if ({imem_waddr, imem_wdata} !== e) begin
                    errors++;
                    $display("FAIL wen_data got addr=%0d data=%h want addr=%0d data=%h",
                             imem_waddr, imem_wdata, e[AW+31:32], e[31:0]);
                end
            end
        end
    end

    // Called at #1 after a posedge; leaves the bench at #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Sends a full frame of n words from frame_w; queues the expected writes.
    task automatic send_frame(input int n, input logic [7:0] sum_flip);
        logic [7:0] cs;
        logic [31:0] w;
        cs = 8'h00;
        send_byte(8'hA5);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        for (int i = 0; i < n; i++) begin
            w = frame_w[i];
            exp_q.push_back({AW'(i), w});
            for (int k = 0; k < 4; k++) begin
                cs = cs ^ w[8*k +: 8];
                send_byte(w[8*k +: 8]);
            end
        end
        send_byte(cs ^ sum_flip);
    endtask

    task automatic check_outs(input string name, input logic [4:0] want);
        // want = {ins_mem_en, cpu_reset, loaded, done, error}
        checks++;
        if ({ins_mem_en, cpu_reset, loaded, done, error} !== want) begin
            errors++;
            $display("FAIL %s got ins/cpu/loaded/done/err=%b want %b", name,
                     {ins_mem_en, cpu_reset, loaded, done, error}, want);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({imem_wen, imem_waddr, imem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_mem got wen=%b addr=%0d data=%h want 0", imem_wen, imem_waddr,
                     imem_wdata);
        end
        check_outs("reset_ctrl", 5'b11000);
    endtask

    task automatic test_good_frame();
        int d0;
        apply_reset();
        d0 = done_cnt;
        frame_w[0] = 32'h00000013;
        frame_w[1] = 32'h00100193;
        send_frame(2, 8'h00);
        check_outs("good_done", 5'b00110);
        idle(1);
        check_outs("good_after", 5'b00100);
        checks++;
        if (done_cnt - d0 != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL good_pulses got done=%0d pending=%0d want 1 0", done_cnt - d0,
                     exp_q.size());
        end
    endtask

    task automatic test_bad_checksum();
        int d0;
        apply_reset();
        d0 = done_cnt;
        frame_w[0] = 32'h00000013;
        frame_w[1] = 32'h00100193;
        send_frame(2, 8'h03);
        check_outs("badsum_err", 5'b11001);
        checks++;
        if (done_cnt != d0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL badsum_writes got done=%0d pending=%0d want 0 0", done_cnt - d0,
                     exp_q.size());
        end
        frame_w[0] = 32'hDEADBEEF;
        send_frame(1, 8'h00);
        check_outs("badsum_recover", 5'b00110);
    endtask

    task automatic test_bad_count();
        int w0;
        apply_reset();
        w0 = wen_cnt;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        check_outs("n_zero", 5'b11001);
        send_byte(8'hA5);
        check_outs("n_restart", 5'b11000);
        send_byte(8'h01); send_byte(8'h02);
        idle(3);
        check_outs("n_513", 5'b11001);
        checks++;
        if (wen_cnt != w0) begin
            errors++;
            $display("FAIL badcount_wen got %0d writes want 0", wen_cnt - w0);
        end
        // 512 words is the largest legal count: must not error on the header.
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
        check_outs("n_512", 5'b11000);
    endtask

    task automatic test_timeout();
        int w0;
        apply_reset();
        w0 = wen_cnt;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00);
        idle(40);
        check_outs("tmo_early", 5'b11000);
        idle(20);
        check_outs("tmo_fire", 5'b11001);
        checks++;
        if (wen_cnt != w0) begin
            errors++;
            $display("FAIL tmo_wen got %0d writes want 0", wen_cnt - w0);
        end
    endtask

    task automatic test_idle_ignore();
        int w0;
        apply_reset();
        w0 = wen_cnt;
        send_byte(8'h13); send_byte(8'hA4); send_byte(8'h00);
        idle(2);
        check_outs("ignore_idle", 5'b11000);
        frame_w[0] = 32'h12345678;
        send_frame(1, 8'h00);
        idle(1);
        send_byte(8'h13);
        check_outs("ignore_loaded", 5'b00100);
        send_byte(8'hA5);
        check_outs("resync", 5'b11000);
        checks++;
        if (wen_cnt - w0 != 1) begin
            errors++;
            $display("FAIL ignore_wen got %0d writes want 1", wen_cnt - w0);
        end
    endtask

    task automatic test_back_to_back_reset();
        apply_reset();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        exp_q.push_back({AW'(0), 32'h44332211});
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66);
        apply_reset();
        checks++;
        if ({imem_wen, imem_waddr, imem_wdata} !== '0) begin
            errors++;
            $display("FAIL midreset_mem got wen=%b addr=%0d data=%h want 0", imem_wen,
                     imem_waddr, imem_wdata);
        end
        check_outs("midreset_ctrl", 5'b11000);
        frame_w[0] = 32'hCAFEF00D;
        frame_w[1] = 32'h0BADC0DE;
        frame_w[2] = 32'hA5A5A5A5;
        send_frame(3, 8'h00);
        check_outs("midreset_reload", 5'b00110);
        idle(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_pending got %0d want 0", exp_q.size());
        end
    endtask

    initial begin
        @(posedge clock);
        #1;
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_bad_count();
        test_timeout();
        test_idle_ignore();
        test_back_to_back_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
